// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C read-path serializer.
//   I2C_ADDR_W / I2C_DATA_W : default memory address and data widths
//   SLAVE_ADDR_PREFIX       : fixed upper nibble of the 7-bit slave address
//   state_e                 : serializer FSM encoding
//   ctl_t                   : registered control outputs of the serializer
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 11;
  localparam int unsigned I2C_DATA_W = 8;
  localparam int unsigned BYTE_BITS  = 8;
  localparam int unsigned BIT_CNT_W  = 4;

  localparam logic [3:0] SLAVE_ADDR_PREFIX = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_MACK  = 3'd4
  } state_e;

  typedef struct packed {
    logic sda_oe;
    logic mem_re;
    logic byte_sent;
    logic nack_seen;
  } ctl_t;

endpackage

// File: rtl/i2c_edge_sync.sv
// Two-flop synchroniser for an I2C pin plus edge pulses.
//   Clock, Reset : system clock, async active-low reset (flops reset to 1 = bus idle)
//   pin_raw      : unsynchronised pin level
//   level        : synchronised level
//   rise_c       : one-cycle pulse, synchronised level went 0 -> 1
//   fall_c       : one-cycle pulse, synchronised level went 1 -> 0
module i2c_edge_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic pin_raw,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level  = sync_q;
  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_serializer.sv
// I2C slave read-path serializer: fetches bytes from memory and shifts them
// out on SDA (open-drain), one bit per SCL falling edge, then samples the
// master ACK/NACK and either continues the burst or returns to idle.
//   Clock, Reset           : system clock, async active-low reset
//   i2c_scl_raw/sda_raw    : raw bus pin levels
//   i2c_ack                : deserializer request to pull SDA low (idle only)
//   read_start, rd_addr    : start a read burst at rd_addr
//   stop_in                : STOP/abort, forces idle
//   mem_re/mem_addr        : memory read strobe and address
//   mem_rdata              : memory data, valid one Clock after mem_re
//   sda_oe                 : 1 = pull SDA low
//   busy                   : FSM not idle
//   byte_sent / nack_seen  : master ACK / NACK pulses
module i2c_serializer
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W = I2C_ADDR_W,
  parameter int unsigned DATA_W = I2C_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i2c_scl_raw,
  input  logic              i2c_sda_raw,
  input  logic              i2c_ack,
  input  logic              read_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              stop_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              sda_oe,
  output logic              busy,
  output logic              byte_sent,
  output logic              nack_seen
);

  logic scl_rise, scl_fall, scl_level_unused;
  logic sda_level, sda_rise_unused, sda_fall_unused;

  state_e                 state_q, state_d;
  ctl_t                   ctl_q, ctl_d;
  logic                   busy_q;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [BYTE_BITS-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   byte_done;

  i2c_edge_sync u_scl_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .pin_raw (i2c_scl_raw),
    .level   (scl_level_unused),
    .rise_c  (scl_rise),
    .fall_c  (scl_fall)
  );

  i2c_edge_sync u_sda_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .pin_raw (i2c_sda_raw),
    .level   (sda_level),
    .rise_c  (sda_rise_unused),
    .fall_c  (sda_fall_unused)
  );

  // All eight data bits have been put on the bus
  assign byte_done = (bit_cnt_q == BIT_CNT_W'(BYTE_BITS));

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; stop_in overrides everything
  always_comb begin
    state_d = state_q;
    if (stop_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (read_start) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_SHIFT;
        ST_SHIFT: if (scl_fall && byte_done) state_d = ST_MACK;
        ST_MACK:  if (scl_rise) state_d = sda_level ? ST_IDLE : ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values; sda_oe only moves on SCL falls outside idle
  always_comb begin
    ctl_d.sda_oe    = ctl_q.sda_oe;
    ctl_d.mem_re    = 1'b0;
    ctl_d.byte_sent = 1'b0;
    ctl_d.nack_seen = 1'b0;
    addr_d          = addr_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    if (stop_in) begin
      ctl_d.sda_oe = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ctl_d.sda_oe = i2c_ack;
          if (read_start) begin
            addr_d       = rd_addr;
            ctl_d.mem_re = 1'b1;
          end
        end
        ST_LOAD: begin
          shift_d   = BYTE_BITS'(mem_rdata);
          bit_cnt_d = '0;
        end
        ST_SHIFT: begin
          if (scl_fall) begin
            if (byte_done) begin
              ctl_d.sda_oe = 1'b0;
            end else begin
              ctl_d.sda_oe = ~shift_q[BYTE_BITS-1];
              shift_d      = {shift_q[BYTE_BITS-2:0], 1'b0};
              bit_cnt_d    = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        ST_MACK: begin
          if (scl_rise) begin
            if (!sda_level) begin
              ctl_d.byte_sent = 1'b1;
              ctl_d.mem_re    = 1'b1;
              addr_d          = addr_q + ADDR_W'(1);
            end else begin
              ctl_d.nack_seen = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers; the address counter doubles as mem_addr
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ctl_q     <= '0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      ctl_q     <= ctl_d;
      busy_q    <= (state_d != ST_IDLE);
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign mem_re    = ctl_q.mem_re;
  assign mem_addr  = addr_q;
  assign sda_oe    = ctl_q.sda_oe;
  assign busy      = busy_q;
  assign byte_sent = ctl_q.byte_sent;
  assign nack_seen = ctl_q.nack_seen;

endmodule

// File: tb/tb_i2c_serializer.sv
// Self-checking bench for i2c_serializer: a bus-level master plus a memory
// model; expected SDA bits, address sequence and ACK/NACK pulse counts come
// from the byte contents and burst rules, checked every cycle they matter.
module tb_i2c_serializer;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMASK  = 2047;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              i2c_scl_raw = 1'b1;
  logic              i2c_sda_raw = 1'b1;
  logic              i2c_ack = 1'b0;
  logic              read_start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              stop_in = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic              sda_oe;
  logic              busy;
  logic              byte_sent;
  logic              nack_seen;

  i2c_serializer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .i2c_scl_raw (i2c_scl_raw),
    .i2c_sda_raw (i2c_sda_raw),
    .i2c_ack     (i2c_ack),
    .read_start  (read_start),
    .rd_addr     (rd_addr),
    .stop_in     (stop_in),
    .mem_rdata   (mem_rdata),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .sda_oe      (sda_oe),
    .busy        (busy),
    .byte_sent   (byte_sent),
    .nack_seen   (nack_seen)
  );

  always #5 Clock = ~Clock;

  logic [7:0] mem [0:2047];

  // Memory responds one Clock after the read strobe
  always @(posedge Clock) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int half   = 10;
  int bs_cnt = 0;
  int nk_cnt = 0;
  bit sda_chk  = 1'b0;
  bit busy_chk = 1'b0;
  logic exp_sda = 1'b0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W-1:0] re_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: read addresses, driven bit during SCL high, busy
  initial begin
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        if (mem_re) begin
          re_log.push_back(mem_addr);
          if (exp_addr_q.size() == 0) begin
            check("unexpected_mem_re", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            a = exp_addr_q.pop_front();
            check("mem_addr", 32'(mem_addr), 32'(a));
          end
        end
        if (sda_chk) check("sda_oe_bit", 32'(sda_oe), 32'(exp_sda));
        if (busy_chk) check("busy_in_shift", 32'(busy), 32'd1);
        if (byte_sent) bs_cnt++;
        if (nack_seen) nk_cnt++;
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // One SCL low/high period; the slave bit is checked while SCL is high
  task automatic scl_bit(input logic exp, input logic sda_val, input bit bchk, output logic bus);
    i2c_scl_raw = 1'b0;
    i2c_sda_raw = sda_val;
    clk_n(half);
    exp_sda  = exp;
    sda_chk  = 1'b1;
    busy_chk = bchk;
    i2c_scl_raw = 1'b1;
    clk_n(half);
    bus      = ~sda_oe;
    sda_chk  = 1'b0;
    busy_chk = 1'b0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a);
    rd_addr    = a;
    read_start = 1'b1;
    clk_n(1);
    read_start = 1'b0;
  endtask

  // Full burst of nbytes: ACK all but the last, NACK the last
  task automatic do_read(input int unsigned addr, input int nbytes, input bit poke, output logic [7:0] bus0);
    int unsigned cur;
    int bs0, nk0;
    logic [7:0] b, bus;
    logic obs, last;
    bs0 = bs_cnt;
    nk0 = nk_cnt;
    cur = addr & AMASK;
    exp_addr_q.push_back(ADDR_W'(cur));
    pulse_start(ADDR_W'(cur));
    clk_n(4);
    bus0 = '0;
    for (int k = 0; k < nbytes; k++) begin
      b = mem[cur];
      for (int i = 7; i >= 0; i--) begin
        scl_bit(~b[i], 1'b1, 1'b1, obs);
        bus[i] = obs;
      end
      if (k == 0) bus0 = bus;
      last = (k == nbytes - 1);
      i2c_scl_raw = 1'b0;
      i2c_sda_raw = last;
      if (poke) begin
        clk_n(5);
        pulse_start(ADDR_W'($urandom));
        clk_n(half - 6);
      end else begin
        clk_n(half);
      end
      if (!last) exp_addr_q.push_back(ADDR_W'((cur + 1) & AMASK));
      exp_sda = 1'b0;
      sda_chk = 1'b1;
      i2c_scl_raw = 1'b1;
      clk_n(half);
      sda_chk = 1'b0;
      cur = (cur + 1) & AMASK;
    end
    i2c_sda_raw = 1'b1;
    clk_n(4);
    check("busy_after_nack", 32'(busy), 32'd0);
    check("sda_oe_after_nack", 32'(sda_oe), 32'd0);
    check("byte_sent_count", 32'(bs_cnt - bs0), 32'(nbytes - 1));
    check("nack_seen_count", 32'(nk_cnt - nk0), 32'd1);
    check("reads_outstanding", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] bus0, b;
    logic obs;
    int unsigned a;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

    // Outputs while reset is held
    repeat (3) begin
      @(negedge Clock);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_pulses", 32'({byte_sent, nack_seen}), 32'd0);
    end
    @(posedge Clock);
    #1 Reset = 1'b1;
    clk_n(4);

    // Idle ACK pass-through: 9 clocks high, one clock late
    i2c_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      clk_n(1);
      check("idle_ack_sda_oe", 32'(sda_oe), 32'(i <= 8));
      if (i == 8) i2c_ack = 1'b0;
    end
    clk_n(2);

    // Known byte 0xA5 at 0x005, NACK
    mem[5] = 8'hA5;
    do_read(5, 1, 1'b0, bus0);
    check("byte_a5_on_bus", 32'(bus0), 32'h0000_00A5);

    // Wrapping burst from the top address
    re_log.delete();
    do_read(11'h7FF, 3, 1'b0, bus0);
    check("wrap_reads", 32'(re_log.size()), 32'd3);
    if (re_log.size() == 3) begin
      check("wrap_addr0", 32'(re_log[0]), 32'h7FF);
      check("wrap_addr1", 32'(re_log[1]), 32'h000);
      check("wrap_addr2", 32'(re_log[2]), 32'h001);
    end

    // read_start during MACK is ignored
    do_read(11'h123, 3, 1'b1, bus0);

    // stop_in together with read_start in idle
    stop_in = 1'b1;
    pulse_start(11'h055);
    stop_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("idle_stop_busy", 32'(busy), 32'd0);
      clk_n(1);
    end

    // stop_in during bit 4, with a simultaneous read_start
    a = 11'h200;
    mem[a] = 8'h00;
    exp_addr_q.push_back(ADDR_W'(a));
    pulse_start(ADDR_W'(a));
    clk_n(4);
    for (int i = 0; i < 4; i++) scl_bit(1'b1, 1'b1, 1'b1, obs);
    i2c_scl_raw = 1'b0;
    clk_n(5);
    check("stop_pre_sda_oe", 32'(sda_oe), 32'd1);
    stop_in = 1'b1;
    pulse_start(11'h3AA);
    stop_in = 1'b0;
    check("stop_sda_oe", 32'(sda_oe), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    clk_n(3);
    i2c_scl_raw = 1'b1;
    clk_n(20);
    check("stop_busy_later", 32'(busy), 32'd0);
    check("stop_reads", 32'(exp_addr_q.size()), 32'd0);

    // Reset in the middle of SHIFT
    a = 11'h3C0;
    mem[a] = mem[a] & 8'hF7;
    b = mem[a];
    exp_addr_q.push_back(ADDR_W'(a));
    pulse_start(ADDR_W'(a));
    clk_n(4);
    for (int i = 7; i >= 4; i--) scl_bit(~b[i], 1'b1, 1'b1, obs);
    i2c_scl_raw = 1'b0;
    clk_n(5);
    check("rst_mid_pre_sda_oe", 32'(sda_oe), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    i2c_scl_raw = 1'b1;
    clk_n(2);
    Reset = 1'b1;
    for (int i = 0; i < 9; i++) scl_bit(1'b0, 1'b1, 1'b0, obs);
    check("rst_mid_busy_after", 32'(busy), 32'd0);
    check("rst_mid_reads", 32'(exp_addr_q.size()), 32'd0);

    // Random bursts, SCL rates and MACK pokes
    for (int t = 0; t < 10; t++) begin
      half = int'($urandom_range(14, 8));
      do_read($urandom_range(2047, 0), int'($urandom_range(4, 1)), bit'($urandom_range(1, 0)), bus0);
      clk_n(int'($urandom_range(10, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_serializer.md
I2C_SERIALIZER -- requirements
Module: i2c_serializer

Interface
REQ-001 Parameters: ADDR_W, default 11, memory byte-address width; DATA_W, default 8, byte width.
REQ-002 Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 i2c_scl_raw  input  1  unsynchronised SCL pin level.
REQ-005 i2c_sda_raw  input  1  unsynchronised SDA pin level, used for master ACK/NACK sampling.
REQ-006 i2c_ack  input  1  deserializer request to drive the slave ACK bit low.
REQ-007 read_start  input  1  single-cycle pulse that starts a read burst.
REQ-008 rd_addr  input  ADDR_W  burst start address, sampled with read_start.
REQ-009 stop_in  input  1  STOP/abort from the deserializer, level.
REQ-010 mem_rdata  input  DATA_W  memory read data, valid one Clock after mem_re.
REQ-011 mem_re  output  1  memory read strobe, one cycle wide.
REQ-012 mem_addr  output  ADDR_W  memory read address.
REQ-013 sda_oe  output  1  1 = pull SDA low (open-drain enable); 0 = release.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 byte_sent  output  1  one-cycle pulse when the master ACKs a byte.
REQ-016 nack_seen  output  1  one-cycle pulse when the master NACKs a byte.

Function
REQ-017 SCL and SDA each pass through 2 flops; edge detect compares the synchronised sample with its previous value, so edges are reported 3 Clocks after the raw pin changes.
REQ-018 States: IDLE, FETCH, LOAD, SHIFT, MACK.
REQ-019 IDLE: sda_oe is registered from i2c_ack (1-cycle latency); all other outputs are 0.
REQ-020 IDLE with read_start=1 and stop_in=0: latch rd_addr into the address counter, assert mem_re with mem_addr=rd_addr, go to FETCH.
REQ-021 FETCH goes to LOAD after one cycle; LOAD captures mem_rdata into an 8-bit shift register, sets bit count to 0, and goes to SHIFT.
REQ-022 SHIFT: on each SCL falling edge, set sda_oe = NOT shift[7], shift left, and increment the bit count.
REQ-023 SHIFT: on the SCL falling edge after bit count reaches 8, set sda_oe=0 and go to MACK.
REQ-024 sda_oe never changes while synchronised SCL is high, except on stop_in or reset.
REQ-025 MACK: on the SCL rising edge, sample synchronised SDA.
REQ-026 MACK sample 0 (ACK): pulse byte_sent, increment the address modulo 2^ADDR_W (2047 wraps to 0), assert mem_re, go to FETCH.
REQ-027 MACK sample 1 (NACK): pulse nack_seen, go to IDLE.
REQ-028 Clock frequency shall be at least 16x SCL, so FETCH/LOAD always complete before the next SCL falling edge.
REQ-029 stop_in=1 in any state: next state IDLE, sda_oe=0, mem_re=0, in the following cycle; this overrides i2c_ack.
REQ-030 stop_in and read_start together: stop wins and the read is not started.
REQ-031 read_start while busy=1 is ignored.
REQ-032 mem_addr holds its value outside mem_re cycles.

Reset
REQ-033 Reset low asynchronously forces: state IDLE, sda_oe=0, mem_re=0, mem_addr=0, busy=0, byte_sent=0, nack_seen=0, shift register 0, bit count 0, sync flops 1 (bus idle).
REQ-034 Reset release mid-transfer leaves the block in IDLE; no bit is driven until a new read_start.

Structure
REQ-035 Shared package i2c_pkg holds the state encoding, ADDR_W and DATA_W constants, and the slave-address prefix 4'b1010.
REQ-036 One sub-module, i2c_edge_sync: 2-flop synchroniser plus rise/fall pulse generation, instantiated once for SCL and once for SDA.

Verification
REQ-037 Reset mid-SHIFT -> sda_oe=0 and busy=0 immediately; no mem_re after release.
REQ-038 i2c_ack high 9 Clocks in IDLE -> sda_oe high 9 Clocks, delayed by 1.
REQ-039 read_start with rd_addr=0x005, mem[5]=0xA5, master NACK -> SDA bits 1,0,1,0,0,1,0,1, released on the 9th bit, then nack_seen pulse and IDLE.
REQ-040 Burst from 0x7FF with master ACK, ACK, NACK -> mem_addr 0x7FF, 0x000, 0x001; byte_sent pulses twice.
REQ-041 stop_in asserted during bit 4 -> sda_oe=0 next cycle and IDLE; a read_start asserted in the same cycle as stop_in is ignored.
REQ-042 read_start asserted during MACK -> ignored; the address sequence is unchanged.
